// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between two writeback lanes through a
// small in-order queue, with youngest-entry forwarding to decode.
module wb_port_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       regwritew,
  input  logic [AW-1:0]              writeregw,
  input  logic [DW-1:0]              resultw,
  input  logic                       regwritew2,
  input  logic [AW-1:0]              writeregw2,
  input  logic [DW-1:0]              resultw2,
  output logic                       stallw,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_wa,
  output logic [DW-1:0]              rf_wd,
  input  logic [AW-1:0]              ra1,
  input  logic [AW-1:0]              ra2,
  output logic                       hit1,
  output logic                       hit2,
  output logic [DW-1:0]              fwd1,
  output logic [DW-1:0]              fwd2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_occ;
  logic [CW:0]   w_free;
  logic          w_stall;
  logic          w_v1;
  logic          w_v2;
  logic          w_push1;
  logic          w_push2;
  logic [PW-1:0] w_tail2;
  logic [CW-1:0] w_npush;

  assign w_occ   = (r_count != '0);
  // The head slot frees up at this edge, so it counts toward room for a pair.
  assign w_free  = (CW+1)'(DEPTH) - {1'b0, r_count} + (CW+1)'(w_occ);
  assign w_stall = (w_free < (CW+1)'(2));

  // Same-destination pair: the younger lane supersedes the older one.
  assign w_v2    = regwritew2 && (writeregw2 != '0);
  assign w_v1    = regwritew && (writeregw != '0) &&
                   !(w_v2 && (writeregw == writeregw2));
  assign w_push1 = !w_stall && w_v1;
  assign w_push2 = !w_stall && w_v2;
  assign w_tail2 = r_tail + PW'(w_push1);
  assign w_npush = CW'(w_push1) + CW'(w_push2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_occ);
      r_tail  <= r_tail + PW'(w_push1) + PW'(w_push2);
      r_count <= r_count + w_npush - CW'(w_occ);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push1) begin
      r_addr[r_tail] <= writeregw;
      r_data[r_tail] <= resultw;
    end
    if (w_push2) begin
      r_addr[w_tail2] <= writeregw2;
      r_data[w_tail2] <= resultw2;
    end
  end

  assign stallw = w_stall;
  assign rf_we  = w_occ;
  assign rf_wa  = w_occ ? r_addr[r_head] : '0;
  assign rf_wd  = w_occ ? r_data[r_head] : '0;
  assign count  = r_count;

  // Walk from head to tail so later matches (younger writes) override.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        if ((ra1 != '0) && (r_addr[r_head + PW'(i)] == ra1)) begin
          hit1 = 1'b1;
          fwd1 = r_data[r_head + PW'(i)];
        end
        if ((ra2 != '0) && (r_addr[r_head + PW'(i)] == ra2)) begin
          hit2 = 1'b1;
          fwd2 = r_data[r_head + PW'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic checked
// against a queue-based model of the writeback port.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk;
  logic          resetn;
  logic          regwritew, regwritew2;
  logic [AW-1:0] writeregw, writeregw2;
  logic [DW-1:0] resultw, resultw2;
  logic          stallw, rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [AW-1:0] ra1, ra2;
  logic          hit1, hit2;
  logic [DW-1:0] fwd1, fwd2;
  logic [2:0]    count;

  wb_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .regwritew(regwritew), .writeregw(writeregw), .resultw(resultw),
    .regwritew2(regwritew2), .writeregw2(writeregw2), .resultw2(resultw2),
    .stallw(stallw), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .ra1(ra1), .ra2(ra2), .hit1(hit1), .hit2(hit2),
    .fwd1(fwd1), .fwd2(fwd2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_stall();
    int n;
    n = q.size();
    return (DEPTH - n + ((n > 0) ? 1 : 0)) < 2;
  endfunction

  function automatic void m_fwd(input logic [AW-1:0] ra, output logic h, output logic [DW-1:0] f);
    h = 1'b0;
    f = '0;
    if (ra != '0)
      foreach (q[i])
        if (q[i].a == ra) begin
          h = 1'b1;
          f = q[i].d;
        end
  endfunction

  task automatic check_model();
    logic          h;
    logic [DW-1:0] f;
    chk("count", 64'(count), 64'(q.size()));
    chk("stallw", 64'(stallw), 64'(m_stall()));
    chk("rf_we", 64'(rf_we), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("rf_wa", 64'(rf_wa), 64'(q[0].a));
      chk("rf_wd", 64'(rf_wd), 64'(q[0].d));
    end else begin
      chk("rf_port_known", 64'($isunknown({rf_wa, rf_wd})), 64'(0));
    end
    m_fwd(ra1, h, f);
    chk("hit1", 64'(hit1), 64'(h));
    chk("fwd1", 64'(fwd1), 64'(f));
    m_fwd(ra2, h, f);
    chk("hit2", 64'(hit2), 64'(h));
    chk("fwd2", 64'(fwd2), 64'(f));
  endtask

  // Pop the head, then append accepted lanes in program order.
  task automatic model_edge();
    bit st;
    bit v1, v2;
    st = m_stall();
    if (q.size() > 0) void'(q.pop_front());
    if (!st) begin
      v2 = regwritew2 && (writeregw2 != 0);
      v1 = regwritew && (writeregw != 0) && !(v2 && writeregw == writeregw2);
      if (v1) q.push_back({writeregw, resultw});
      if (v2) q.push_back({writeregw2, resultw2});
    end
  endtask

  task automatic step(input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                      input logic [AW-1:0] q1, input logic [AW-1:0] q2);
    regwritew = w1; writeregw = a1; resultw = d1;
    regwritew2 = w2; writeregw2 = a2; resultw2 = d2;
    ra1 = q1; ra2 = q2;
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int sat_cnt [10] = '{0, 2, 3, 4, 3, 4, 3, 4, 3, 4};

  initial begin
    regwritew = 0; writeregw = 0; resultw = 0;
    regwritew2 = 0; writeregw2 = 0; resultw2 = 0;
    ra1 = 0; ra2 = 0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_stallw", 64'(stallw), 64'(0));
    chk("rst_hit1", 64'(hit1), 64'(0));
    chk("rst_fwd1", 64'(fwd1), 64'(0));
    @(negedge clk);
    resetn = 1'b1;

    // single write
    step(1, 5, 32'h0000_1234, 0, 0, 0, 0, 0);
    chk("single_we", 64'(rf_we), 64'(1));
    chk("single_wa", 64'(rf_wa), 64'(5));
    chk("single_wd", 64'(rf_wd), 64'h1234);
    idle(1);
    chk("single_idle_we", 64'(rf_we), 64'(0));
    chk("single_idle_cnt", 64'(count), 64'(0));

    // dual ordering
    step(1, 3, 32'hA, 1, 4, 32'hB, 0, 0);
    chk("dual_wa0", 64'(rf_wa), 64'(3));
    chk("dual_wd0", 64'(rf_wd), 64'hA);
    idle(1);
    chk("dual_wa1", 64'(rf_wa), 64'(4));
    chk("dual_wd1", 64'(rf_wd), 64'hB);
    idle(1);
    chk("dual_idle_we", 64'(rf_we), 64'(0));

    // same destination, then write to r0
    step(1, 7, 32'h1, 1, 7, 32'h2, 0, 0);
    chk("same_cnt", 64'(count), 64'(1));
    chk("same_wa", 64'(rf_wa), 64'(7));
    chk("same_wd", 64'(rf_wd), 64'h2);
    idle(1);
    chk("same_done", 64'(count), 64'(0));
    step(1, 0, 32'hFF, 0, 0, 0, 0, 0);
    chk("r0_cnt", 64'(count), 64'(0));
    chk("r0_we", 64'(rf_we), 64'(0));

    // saturation
    for (int i = 0; i < 10; i++) begin
      chk("sat_count", 64'(count), 64'(sat_cnt[i]));
      chk("sat_stall", 64'(stallw), 64'(sat_cnt[i] == 4));
      step(1, AW'(8 + i), $urandom, 1, AW'(20 + i), $urandom, 0, 0);
    end
    idle(5);

    // forwarding: two writes to r9 queued behind a busy head
    step(1, 1, 32'hAA, 1, 9, 32'h11, 0, 0);
    step(1, 9, 32'h22, 0, 0, 0, 0, 0);
    ra1 = 9; ra2 = 0;
    #1;
    chk("fwd_hit1", 64'(hit1), 64'(1));
    chk("fwd_fwd1", 64'(fwd1), 64'h22);
    chk("fwd_hit2", 64'(hit2), 64'(0));
    chk("fwd_fwd2", 64'(fwd2), 64'(0));
    idle(3);

    // reset with three writes queued
    step(1, 2, 32'h2222, 1, 3, 32'h3333, 0, 0);
    step(1, 4, 32'h4444, 1, 6, 32'h6666, 0, 0);
    chk("mid_pre_cnt", 64'(count), 64'(3));
    regwritew = 0; regwritew2 = 0;
    ra1 = 3;
    #2 resetn = 1'b0;
    #1;
    chk("mid_rf_we", 64'(rf_we), 64'(0));
    chk("mid_count", 64'(count), 64'(0));
    chk("mid_stallw", 64'(stallw), 64'(0));
    chk("mid_hit1", 64'(hit1), 64'(0));
    q.delete();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    idle(2);
    chk("post_rst_we", 64'(rf_we), 64'(0));

    // random traffic over a small register range to provoke hits and collisions
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), $urandom,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the two writeback lanes of the dual-issue pipeline. Each cycle it accepts up to two write requests, from lane 1 (older) and lane 2 (younger), after the writeback result muxes. Accepted requests are queued in program order and retired one per cycle to the register file. The block also provides queued-write forwarding to decode and stalls the pipeline when the queue cannot absorb a full issue pair.

## Interface
- DEPTH, 4: number of queue entries; power of two, at least 2.
- AW, 5: register address width.
- DW, 32: data width.

- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- regwritew  in  1  lane 1 write request.
- writeregw  in  AW  lane 1 destination register.
- resultw  in  DW  lane 1 write data.
- regwritew2  in  1  lane 2 write request.
- writeregw2  in  AW  lane 2 destination register.
- resultw2  in  DW  lane 2 write data.
- stallw  out  1  inputs are not accepted this cycle; upstream holds the writeback stage.
- rf_we  out  1  register file write enable.
- rf_wa  out  AW  register file write address.
- rf_wd  out  DW  register file write data.
- ra1, ra2  in  AW  decode lookup addresses.
- hit1, hit2  out  1  a queued write targets ra1 / ra2.
- fwd1, fwd2  out  DW  data of the youngest queued write to ra1 / ra2.
- count  out  $clog2(DEPTH)+1  number of occupied queue entries.

## Operation
- **Queue structure.** Circular queue with head and tail pointers that wrap modulo DEPTH, plus an occupancy count.
- **Lane qualification.**
  - A lane is valid when its request is high and its destination is not 0. Writes to r0 are silently discarded.
  - If both lanes are valid with the same destination, lane 1 is dropped and only lane 2 is enqueued (last writer wins).
- **Enqueue.** When stallw=0, valid lanes are enqueued in order: lane 1 first, then lane 2. Enqueued entries pack contiguously at the tail, so 0, 1 or 2 entries are pushed per cycle. When stallw=1, both lanes are ignored entirely.
- **Retire.**
  - Whenever count>0, rf_we=1 and rf_wa/rf_wd come from the head entry; the head is popped at that clock edge.
  - When count=0, rf_we=0. rf_wa and rf_wd are don't-care but must not contain X.
- **Stall.** Effective free slots = DEPTH - count + (count>0 ? 1 : 0). stallw=1 iff effective free slots < 2. stallw is decided from the registered count only, independent of the current requests.
- **Simultaneous push and pop** in the same cycle is legal: count_next = count + pushes - pop.
- **Forwarding lookup.** Combinational search over occupied entries.
  - hitN=1 iff some occupied entry's address equals raN and raN != 0.
  - fwdN is the data of the youngest such entry (nearest the tail); fwdN=0 when there is no hit.
  - The search includes the head entry currently being written. It excludes requests arriving in the current cycle.
- **Reset.** Asserting resetn low immediately clears count and both pointers. Any queued writes are lost.
  - Outputs during and after reset: rf_we=0, stallw=0, hit1=hit2=0, fwd1=fwd2=0, count=0.

## Timing
- **Write latency.** An accepted request reaches the register file port one cycle after acceptance at the earliest. An entry queued at position k behind the head retires k cycles later.
- **Throughput.** One register file write per cycle, up to two acceptances per cycle.
- **Steady dual issue.** With DEPTH=4 and two valid writes every cycle starting from empty, count runs 0, 2, 3, 4, 3, 4, 3, ... and stallw is high in every cycle where count=4.
- **Combinational paths.**
  - stallw, rf_we, rf_wa, rf_wd and count depend only on registered state.
  - hitN and fwdN depend on registered state and raN.
- **Reset release.** Deassertion of resetn is synchronized externally; the block accepts requests from the first rising edge after release.

## Test plan
- **Single write:** lane 1 writes r5=0x00001234, lane 2 idle → next cycle rf_we=1, rf_wa=5, rf_wd=0x00001234; the following cycle rf_we=0 and count=0.
- **Dual ordering:** lane 1 writes r3=0xA, lane 2 writes r4=0xB in the same cycle → cycle+1 writes r3=0xA, cycle+2 writes r4=0xB, then the port goes idle.
- **Same destination and r0:**
  - lane 1 r7=1 and lane 2 r7=2 → exactly one write, r7=2.
  - lane 1 r0=0xFF, lane 2 idle → no write, count stays 0.
- **Saturation:** dual writes to distinct registers every cycle for 10 cycles, starting empty.
  - count follows 0, 2, 3, 4, 3, 4, ...; stallw high exactly when count=4.
  - Every non-stalled request is written exactly once, in program order.
- **Forwarding:** queue r9=0x11 then r9=0x22 while the port is busy; ra1=9 → hit1=1, fwd1=0x22. With ra2=0 → hit2=0, fwd2=0.
- **Reset mid-operation:** with count=3, drive resetn low between clock edges → rf_we=0, count=0 and stallw=0 immediately, before any clock edge. After release, no stale write appears.
